// File: rtl/timer_a_int_ctl_pkg.sv
// Shared constants and helpers for the TimerA interrupt flag/vector controller.
package timer_a_int_ctl_pkg;

  typedef logic [15:0] taiv_t;

  localparam taiv_t TAIV_NONE  = 16'h0000;
  localparam taiv_t TAIV_CCR1  = 16'h0002;
  localparam taiv_t TAIV_CCR2  = 16'h0004;
  localparam taiv_t TAIV_CCR3  = 16'h0006;
  localparam taiv_t TAIV_CCR4  = 16'h0008;
  localparam taiv_t TAIV_CCR5  = 16'h000A;
  localparam taiv_t TAIV_CCR6  = 16'h000C;
  localparam taiv_t TAIV_TAIFG = 16'h000E;

  // Largest legal channel count (CCR0..CCR6).
  localparam int TAIV_MAXCCR = 7;

  // Vector for capture/compare channel n (1..6); channels outside that range
  // have no vector.
  function automatic taiv_t taiv_ccr(input int n);
    taiv_t v;
    case (n)
      1:       v = TAIV_CCR1;
      2:       v = TAIV_CCR2;
      3:       v = TAIV_CCR3;
      4:       v = TAIV_CCR4;
      5:       v = TAIV_CCR5;
      6:       v = TAIV_CCR6;
      default: v = TAIV_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/timer_a_int_ctl_if.sv
// CPU-bus / interrupt-unit side of the TimerA interrupt controller.
// The master is the CPU/interrupt unit, the slave is the flag controller.
interface timer_a_int_ctl_if #(
  parameter int NCCR = 3
);
  // Software flag image write
  logic            wFlag;
  logic            wTAIFG;
  logic [NCCR-1:0] wCCIFG;
  // Read-to-clear and acknowledge strobes
  logic            IVread;
  logic            INTACK0;
  // Flag, vector and request outputs
  logic            TAIFG;
  logic [NCCR-1:0] CCIFG;
  logic [15:0]     TAxIV;
  logic            IRQ0;
  logic            IRQ1;

  modport master (
    output wFlag, wTAIFG, wCCIFG, IVread, INTACK0,
    input  TAIFG, CCIFG, TAxIV, IRQ0, IRQ1
  );

  modport slave (
    input  wFlag, wTAIFG, wCCIFG, IVread, INTACK0,
    output TAIFG, CCIFG, TAxIV, IRQ0, IRQ1
  );
endinterface

// File: rtl/timer_a_iv_prio.sv
// Combinational TAxIV priority encoder.
// pend bit i (i < NCCR-1) is CCIFG[i+1]; the top bit is TAIFG.
// Lowest index wins, so CCR1 has the highest priority and TAIFG the lowest.
module timer_a_iv_prio
  import timer_a_int_ctl_pkg::*;
#(
  parameter int NCCR = 3
) (
  input  logic [NCCR-1:0] pend_i,
  output logic [NCCR-1:0] sel_o,
  output logic [15:0]     iv_o
);

  logic found;

  // Pick the first pending source and produce its one-hot select and vector.
  always_comb begin
    sel_o = '0;
    iv_o  = TAIV_NONE;
    found = 1'b0;
    for (int i = 0; i < NCCR; i++) begin
      if (pend_i[i] && !found) begin
        found    = 1'b1;
        sel_o[i] = 1'b1;
        iv_o     = (i == NCCR - 1) ? TAIV_TAIFG : taiv_ccr(i + 1);
      end
    end
  end

endmodule

// File: rtl/timer_a_int_ctl.sv
// TimerA interrupt flag and vector controller: edge capture of the set
// levels, flag registers with set/write/clear arbitration, TAxIV generation
// and the two interrupt request lines.
module timer_a_int_ctl
  import timer_a_int_ctl_pkg::*;
#(
  parameter int NCCR = 3
) (
  input  logic            MCLK,
  input  logic            reset,
  input  logic            TAIFGset,
  input  logic [NCCR-1:0] CCIFGset,
  input  logic            TAIE,
  input  logic [NCCR-1:0] CCIE,
  timer_a_int_ctl_if.slave bus
);

  // Previous-cycle copies of the set levels for 0->1 detection
  logic            ta_set_q;
  logic [NCCR-1:0] cc_set_q;

  // Flag registers
  logic            taifg_q, taifg_d;
  logic [NCCR-1:0] ccifg_q, ccifg_d;

  logic            ta_edge;
  logic [NCCR-1:0] cc_edge;
  logic            ta_clr;
  logic [NCCR-1:0] cc_clr;

  logic [NCCR-1:0] pend;
  logic [NCCR-1:0] sel;
  logic [15:0]     iv;

  assign ta_edge = TAIFGset & ~ta_set_q;
  assign cc_edge = CCIFGset & ~cc_set_q;

  // CCR0 is never part of the shared vector.
  assign pend = {taifg_q, ccifg_q[NCCR-1:1]};

  timer_a_iv_prio #(
    .NCCR (NCCR)
  ) u_prio (
    .pend_i (pend),
    .sel_o  (sel),
    .iv_o   (iv)
  );

  // The one-hot select that drives TAxIV also picks the flag an IVread
  // clears, so the bus always clears exactly the source it just read.
  assign ta_clr = bus.IVread & sel[NCCR-1];

  // Per-channel clear requests: INTACK0 for CCR0, IVread select for the rest.
  always_comb begin
    cc_clr    = '0;
    cc_clr[0] = bus.INTACK0;
    for (int n = 1; n < NCCR; n++) begin
      cc_clr[n] = bus.IVread & sel[n-1];
    end
  end

  // Next flag values: hardware set edge, then software write, then clear.
  always_comb begin
    taifg_d = taifg_q;
    if (ta_edge) begin
      taifg_d = 1'b1;
    end else if (bus.wFlag) begin
      taifg_d = bus.wTAIFG;
    end else if (ta_clr) begin
      taifg_d = 1'b0;
    end

    ccifg_d = ccifg_q;
    for (int n = 0; n < NCCR; n++) begin
      if (cc_edge[n]) begin
        ccifg_d[n] = 1'b1;
      end else if (bus.wFlag) begin
        ccifg_d[n] = bus.wCCIFG[n];
      end else if (cc_clr[n]) begin
        ccifg_d[n] = 1'b0;
      end
    end
  end

  // Edge registers load 0 in reset so a level still high on release
  // is seen as a fresh edge.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      ta_set_q <= 1'b0;
      cc_set_q <= '0;
    end else begin
      ta_set_q <= TAIFGset;
      cc_set_q <= CCIFGset;
    end
  end

  // Flag state update.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      taifg_q <= 1'b0;
      ccifg_q <= '0;
    end else begin
      taifg_q <= taifg_d;
      ccifg_q <= ccifg_d;
    end
  end

  assign bus.TAIFG = taifg_q;
  assign bus.CCIFG = ccifg_q;
  assign bus.TAxIV = iv;
  assign bus.IRQ0  = ccifg_q[0] & CCIE[0];
  assign bus.IRQ1  = (taifg_q & TAIE) | (|(ccifg_q[NCCR-1:1] & CCIE[NCCR-1:1]));

endmodule

// File: tb/tb_timer_a_int_ctl.sv
// Bench for timer_a_int_ctl: directed scenarios plus random traffic, with a
// cycle-level reference model feeding a scoreboard checked by a monitor.
module tb_timer_a_int_ctl;

  localparam int NCCR = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            ta_set;
  logic [NCCR-1:0] cc_set;
  logic            taie;
  logic [NCCR-1:0] ccie;

  int errors = 0;
  int checks = 0;

  timer_a_int_ctl_if #(.NCCR(NCCR)) bus ();

  timer_a_int_ctl #(.NCCR(NCCR)) dut (
    .MCLK     (clk),
    .reset    (rst),
    .TAIFGset (ta_set),
    .CCIFGset (cc_set),
    .TAIE     (taie),
    .CCIE     (ccie),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            ta;
    logic [NCCR-1:0] cc;
    logic [15:0]     iv;
    logic            irq0;
    logic            irq1;
  } exp_t;

  exp_t sb_q[$];
  bit   track = 1'b0;

  // Reference model state: flags and last-seen set levels.
  bit m_ta;
  bit m_cc[NCCR];
  bit p_ta;
  bit p_cc[NCCR];

  // Highest-priority pending source: channel number 1..NCCR-1,
  // NCCR for the overflow flag, 0 for none.
  function automatic int model_src();
    for (int n = 1; n < NCCR; n++) if (m_cc[n]) return n;
    if (m_ta) return NCCR;
    return 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   s;
    s      = model_src();
    e.ta   = m_ta;
    for (int n = 0; n < NCCR; n++) e.cc[n] = m_cc[n];
    e.iv   = (s == 0) ? 16'd0 : (s == NCCR) ? 16'h000E : 16'(2 * s);
    e.irq0 = m_cc[0] && ccie[0];
    e.irq1 = m_ta && taie;
    for (int n = 1; n < NCCR; n++) if (m_cc[n] && ccie[n]) e.irq1 = 1'b1;
    return e;
  endfunction

  function automatic bit next_flag(bit cur, bit ed, bit wr, bit wd, bit clr);
    if (ed)  return 1'b1;
    if (wr)  return wd;
    if (clr) return 1'b0;
    return cur;
  endfunction

  function automatic void model_clear();
    m_ta = 0; p_ta = 0;
    for (int n = 0; n < NCCR; n++) begin m_cc[n] = 0; p_cc[n] = 0; end
  endfunction

  // Advance the model by one clock edge using the inputs of the ending cycle.
  function automatic void model_step();
    int s;
    bit clr;
    if (rst) begin
      model_clear();
      return;
    end
    s = model_src();
    m_ta = next_flag(m_ta, ta_set && !p_ta, bus.wFlag, bus.wTAIFG,
                     bus.IVread && s == NCCR);
    for (int n = 0; n < NCCR; n++) begin
      clr = (n == 0) ? bus.INTACK0 : (bus.IVread && s == n);
      m_cc[n] = next_flag(m_cc[n], cc_set[n] && !p_cc[n], bus.wFlag,
                          bus.wCCIFG[n], clr);
    end
    p_ta = ta_set;
    for (int n = 0; n < NCCR; n++) p_cc[n] = cc_set[n];
  endfunction

  // One clock: record what this cycle should show, then take the edge.
  task automatic step();
    if (track) sb_q.push_back(model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: every cycle with an expected entry, compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_taifg", 16'(bus.TAIFG), 16'(e.ta));
        chk("sb_ccifg", 16'(bus.CCIFG), 16'(e.cc));
        chk("sb_taxiv", bus.TAxIV, e.iv);
        chk("sb_irq0",  16'(bus.IRQ0), 16'(e.irq0));
        chk("sb_irq1",  16'(bus.IRQ1), 16'(e.irq1));
      end
    end
  end

  initial begin
    int wait_cnt;
    rst = 1; ta_set = 0; cc_set = '0; taie = 0; ccie = '0;
    bus.wFlag = 0; bus.wTAIFG = 0; bus.wCCIFG = '0; bus.IVread = 0; bus.INTACK0 = 0;
    @(posedge clk); #1;
    model_clear();
    track = 1'b1;
    step();
    rst = 0;
    chk("rst_iv",   bus.TAxIV, 16'h0000);
    chk("rst_irq0", 16'(bus.IRQ0), 16'd0);
    chk("rst_irq1", 16'(bus.IRQ1), 16'd0);

    // Long TAIFGset level sets the flag once only.
    taie = 1; ta_set = 1;
    step();
    chk("ta_first", 16'(bus.TAIFG), 16'd1);
    chk("ta_iv",    bus.TAxIV, 16'h000E);
    chk("ta_irq1",  16'(bus.IRQ1), 16'd1);
    repeat (19) step();
    bus.IVread = 1; step(); bus.IVread = 0;
    chk("ta_rdclr",  16'(bus.TAIFG), 16'd0);
    chk("ta_rd_iv",  bus.TAxIV, 16'h0000);
    chk("ta_rd_irq", 16'(bus.IRQ1), 16'd0);
    repeat (3) step();
    chk("ta_noreset", 16'(bus.TAIFG), 16'd0);
    ta_set = 0; step();

    // Three sources at once, drained by successive IVreads.
    cc_set = 3'b110; ta_set = 1; step(); cc_set = '0; ta_set = 0;
    chk("prio_1", bus.TAxIV, 16'h0002);
    bus.IVread = 1; step();
    chk("prio_2", bus.TAxIV, 16'h0004);
    step();
    chk("prio_ta", bus.TAxIV, 16'h000E);
    step();
    chk("prio_none", bus.TAxIV, 16'h0000);
    bus.IVread = 0;

    // Set edge beats an IVread of the same flag.
    cc_set[2] = 1; step(); cc_set = '0; step();
    chk("race_pre", bus.TAxIV, 16'h0004);
    cc_set[2] = 1; bus.IVread = 1; step(); bus.IVread = 0;
    chk("race_flag", 16'(bus.CCIFG[2]), 16'd1);
    chk("race_iv",   bus.TAxIV, 16'h0004);
    cc_set = '0; bus.IVread = 1; step(); bus.IVread = 0;
    chk("race_clr", bus.TAxIV, 16'h0000);

    // CCR0 uses IRQ0 and INTACK0, never TAxIV.
    ccie = 3'b001; cc_set = 3'b001; step(); cc_set = '0;
    chk("ccr0_irq", 16'(bus.IRQ0), 16'd1);
    chk("ccr0_iv",  bus.TAxIV, 16'h0000);
    bus.INTACK0 = 1; step(); bus.INTACK0 = 0;
    chk("ccr0_ack", 16'(bus.IRQ0), 16'd0);

    // Software write of the flag image.
    ccie = '0; taie = 0;
    bus.wFlag = 1; bus.wCCIFG = 3'b110; bus.wTAIFG = 0; step(); bus.wFlag = 0;
    chk("wr_cc",   16'(bus.CCIFG), 16'h0006);
    chk("wr_iv",   bus.TAxIV, 16'h0002);
    chk("wr_irq1", 16'(bus.IRQ1), 16'd0);

    // Reset with flags pending; a set level held through reset re-fires.
    ccie = 3'b111; taie = 1; ta_set = 1; step();
    rst = 1; step(); rst = 0;
    chk("mrst_cc",   16'(bus.CCIFG), 16'd0);
    chk("mrst_ta",   16'(bus.TAIFG), 16'd0);
    chk("mrst_iv",   bus.TAxIV, 16'h0000);
    chk("mrst_irq0", 16'(bus.IRQ0), 16'd0);
    chk("mrst_irq1", 16'(bus.IRQ1), 16'd0);
    step();
    chk("mrst_refire", 16'(bus.TAIFG), 16'd1);
    ta_set = 0;

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) ta_set = ~ta_set;
      for (int n = 0; n < NCCR; n++) if ($urandom_range(0, 2) == 0) cc_set[n] = ~cc_set[n];
      bus.IVread  = ($urandom_range(0, 3) == 0);
      bus.INTACK0 = ($urandom_range(0, 7) == 0);
      bus.wFlag   = ($urandom_range(0, 15) == 0);
      bus.wTAIFG  = 1'($urandom);
      bus.wCCIFG  = NCCR'($urandom);
      rst         = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) begin
        taie = 1'($urandom);
        ccie = NCCR'($urandom);
      end
      step();
    end
    rst = 0; bus.IVread = 0; bus.INTACK0 = 0; bus.wFlag = 0;
    track = 1'b0;

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    checks++;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
